// File: rtl/ysyx_25060170_ifu_pkg.sv
// Shared widths, start PC, opcodes, FSM states and immediate decoders for the fetch unit.
// Relocate the reset fetch address through the START_PC parameter of the fetch unit.
package ysyx_25060170_ifu_pkg;

  localparam int unsigned PC_W   = 32;
  localparam int unsigned INST_W = 32;

  localparam logic [PC_W-1:0] STARTPC = 32'h8000_0000;

  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_OUT,
    ST_DROP
  } ifu_state_e;

  function automatic logic [PC_W-1:0] imm_j(input logic [INST_W-1:0] inst);
    return {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

  function automatic logic [PC_W-1:0] imm_b(input logic [INST_W-1:0] inst);
    return {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
  endfunction

endpackage

// File: rtl/ysyx_25060170_ifu_if.sv
// Redirect, instruction-memory and IF/ID handshake bundle of the fetch unit.
// master = fetch unit side, slave = memory / pipeline environment side.
interface ysyx_25060170_ifu_if;
    import ysyx_25060170_ifu_pkg::*;

    logic              redirect_valid;
    logic [PC_W-1:0]   redirect_pc;
    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [PC_W-1:0]   imem_addr;
    logic              imem_rsp_valid;
    logic [INST_W-1:0] imem_rsp_data;
    logic              if_valid;
    logic              id_ready;
    logic [INST_W-1:0] if_inst;
    logic [PC_W-1:0]   if_pc;
    logic              if_jump;

    modport master (
        input  redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid,
               imem_rsp_data, id_ready,
        output imem_req_valid, imem_addr, if_valid, if_inst, if_pc, if_jump
    );

    modport slave (
        output redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid,
               imem_rsp_data, id_ready,
        input  imem_req_valid, imem_addr, if_valid, if_inst, if_pc, if_jump
    );

endinterface

// File: rtl/ysyx_25060170_ifu_bpu.sv
// Static predictor: JAL and backward branches taken. Compiled only when
// YSYX_25060170_STATIC_BPU_EN is defined.
`ifdef YSYX_25060170_STATIC_BPU_EN
module ysyx_25060170_bpu
    import ysyx_25060170_ifu_pkg::*;
(
    input  logic [INST_W-1:0] inst,
    input  logic [PC_W-1:0]   pc,
    output logic              pred_taken,
    output logic [PC_W-1:0]   pred_target
);

    always_comb begin
        pred_taken  = 1'b0;
        pred_target = pc + 32'd4;
        if (inst[6:0] == OPC_JAL) begin
            pred_taken  = 1'b1;
            pred_target = pc + imm_j(inst);
        end else if (inst[6:0] == OPC_BRANCH && inst[31]) begin
            pred_taken  = 1'b1;
            pred_target = pc + imm_b(inst);
        end
    end

endmodule
`endif

// File: rtl/ysyx_25060170_ifu.sv
// Instruction fetch unit: one outstanding imem request, valid/ready hand-off to IF/ID.
// Optional static prediction under YSYX_25060170_STATIC_BPU_EN.
module ysyx_25060170_ifu
    import ysyx_25060170_ifu_pkg::*;
#(
    parameter logic [PC_W-1:0] START_PC = STARTPC
) (
    input  logic                 clk,
    input  logic                 rst,
    ysyx_25060170_ifu_if.master  bus
);

    ifu_state_e        state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [INST_W-1:0] if_inst_q, if_inst_d;
    logic [PC_W-1:0]   if_pc_q, if_pc_d;
    logic [PC_W-1:0]   fetch_addr;
    logic [PC_W-1:0]   next_pc;
    logic              pred_taken;
    logic              req_fire;

    assign fetch_addr = {pc_q[PC_W-1:2], 2'b00};
    assign req_fire   = (state_q == ST_REQ) & bus.imem_req_ready;

`ifdef YSYX_25060170_STATIC_BPU_EN
    logic [PC_W-1:0] pred_target;

    ysyx_25060170_bpu u_bpu (
        .inst        (if_inst_q),
        .pc          (if_pc_q),
        .pred_taken  (pred_taken),
        .pred_target (pred_target)
    );

    assign next_pc = pred_taken ? pred_target : if_pc_q + 32'd4;
`else
    assign pred_taken = 1'b0;
    assign next_pc    = if_pc_q + 32'd4;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            pc_q      <= START_PC;
            if_inst_q <= '0;
            if_pc_q   <= START_PC;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            if_inst_q <= if_inst_d;
            if_pc_q   <= if_pc_d;
        end
    end

    // Redirect beats every transition; an accepted-but-killed request parks in DROP
    // so its response is consumed before the next request goes out.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: state_d = ST_REQ;
            ST_REQ: begin
                if (req_fire)
                    state_d = bus.redirect_valid ? ST_DROP : ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.imem_rsp_valid)
                    state_d = bus.redirect_valid ? ST_REQ : ST_OUT;
                else if (bus.redirect_valid)
                    state_d = ST_DROP;
            end
            ST_OUT: begin
                if (bus.redirect_valid || bus.id_ready)
                    state_d = ST_REQ;
            end
            ST_DROP: begin
                if (bus.imem_rsp_valid)
                    state_d = ST_REQ;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        pc_d      = pc_q;
        if_inst_d = if_inst_q;
        if_pc_d   = if_pc_q;
        if (state_q == ST_WAIT && bus.imem_rsp_valid && !bus.redirect_valid) begin
            if_inst_d = bus.imem_rsp_data;
            if_pc_d   = fetch_addr;
        end
        if (bus.redirect_valid)
            pc_d = bus.redirect_pc;
        else if (state_q == ST_OUT && bus.id_ready)
            pc_d = next_pc;

        bus.imem_req_valid = (state_q == ST_REQ);
        bus.imem_addr      = fetch_addr;
        bus.if_valid       = (state_q == ST_OUT);
        bus.if_inst        = if_inst_q;
        bus.if_pc          = if_pc_q;
        bus.if_jump        = (state_q == ST_OUT) & pred_taken;
    end

endmodule
